// File: rtl/cnn_div_seq_24s_10s_if.sv
// Start/done handshake and operand/result bundle for the sequential signed divider.
`timescale 1ns/1ps
interface cnn_div_seq_24s_10s_if #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 14
);
  logic                  start;
  logic [DIVIDEND_W-1:0] din0;
  logic [DIVISOR_W-1:0]  din1;
  logic                  ready;
  logic                  done;
  logic [QUOT_W-1:0]     quot;
  logic [DIVISOR_W-1:0]  rem;
  logic                  ovf;
  logic                  div0;

  modport master (
    output start, din0, din1,
    input  ready, done, quot, rem, ovf, div0
  );

  modport slave (
    input  start, din0, din1,
    output ready, done, quot, rem, ovf, div0
  );
endinterface

// File: rtl/cnn_div_seq_24s_10s.sv
// Restoring signed divider, 24s / 10s -> saturated 14s quotient and 10s remainder,
// one quotient bit per clock behind a start/done handshake.
`timescale 1ns/1ps
module cnn_div_seq_24s_10s #(
  parameter int DIVIDEND_W = 24,  // only 24 supported
  parameter int DIVISOR_W  = 10,  // only 10 supported
  parameter int QUOT_W     = 14
) (
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  cnn_div_seq_24s_10s_if.slave   bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [QUOT_W-1:0]     QUOT_MAX  = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QUOT_MIN  = {1'b1, {(QUOT_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] POS_LIMIT = DIVIDEND_W'((1 << (QUOT_W-1)) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIMIT = DIVIDEND_W'(1 << (QUOT_W-1));

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, state_nxt;

  // dvd starts as |dividend| and is shifted out MSB-first while quotient bits shift in.
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;
  logic [CNT_W-1:0]      cnt;
  logic                  q_neg;
  logic                  r_neg;

  logic [QUOT_W-1:0]     quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  ovf_q;
  logic                  div0_q;
  logic                  done_q;

  logic [DIVISOR_W:0]    shifted;
  logic                  take;
  logic [DIVISOR_W-1:0]  prem_nxt;
  logic [QUOT_W-1:0]     quot_fin;
  logic [DIVISOR_W-1:0]  rem_fin;
  logic                  ovf_fin;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    shifted  = {prem, dvd[DIVIDEND_W-1]};
    take     = shifted >= {1'b0, dvs};
    prem_nxt = take ? DIVISOR_W'(shifted - {1'b0, dvs}) : shifted[DIVISOR_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    quot_fin = '0;
    rem_fin  = r_neg ? -prem : prem;
    ovf_fin  = 1'b0;
    if (dvs == '0) begin
      quot_fin = r_neg ? QUOT_MIN : QUOT_MAX;
      rem_fin  = '0;
      ovf_fin  = 1'b1;
    end else if (q_neg) begin
      // A magnitude of exactly 2^(QUOT_W-1) is representable when negative.
      if (dvd > NEG_LIMIT) begin
        quot_fin = QUOT_MIN;
        ovf_fin  = 1'b1;
      end else begin
        quot_fin = -dvd[QUOT_W-1:0];
      end
    end else if (dvd > POS_LIMIT) begin
      quot_fin = QUOT_MAX;
      ovf_fin  = 1'b1;
    end else begin
      quot_fin = dvd[QUOT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: every register, datapath included, is cleared so an aborted operation leaves no residue.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      div0_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd   <= bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;
            dvs   <= bus.din1[DIVISOR_W-1]  ? -bus.din1 : bus.din1;
            q_neg <= bus.din0[DIVIDEND_W-1] ^ bus.din1[DIVISOR_W-1];
            r_neg <= bus.din0[DIVIDEND_W-1];
            prem  <= '0;
            cnt   <= CNT_W'(DIVIDEND_W - 1);
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dvd  <= {dvd[DIVIDEND_W-2:0], take};
          cnt  <= cnt - 1'b1;
        end
        FIN: begin
          quot_q <= quot_fin;
          rem_q  <= rem_fin;
          ovf_q  <= ovf_fin;
          div0_q <= (dvs == '0);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done_q;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
  assign bus.ovf   = ovf_q;
  assign bus.div0  = div0_q;

endmodule

// File: tb/tb_cnn_div_seq_24s_10s.sv
// Directed, table-driven bench for the sequential signed divider.
`timescale 1ns/1ps
module tb_cnn_div_seq_24s_10s;

  typedef struct {
    int   a;
    int   b;
    int   q;
    int   r;
    logic o;
    logic d;
  } vec_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  cnn_div_seq_24s_10s_if bus ();

  cnn_div_seq_24s_10s dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sq(input logic [13:0] v);
    logic signed [13:0] s;
    s = v;
    return int'(s);
  endfunction

  function automatic int sr(input logic [9:0] v);
    logic signed [9:0] s;
    s = v;
    return int'(s);
  endfunction

  // Reference: truncating division with quotient saturation to 14 bits.
  task automatic model(input int a, input int b, output int q, output int r);
    int qq;
    if (b == 0) begin
      q = (a >= 0) ? 8191 : -8192;
      r = 0;
    end else begin
      qq = a / b;
      r  = a % b;
      q  = (qq > 8191) ? 8191 : (qq < -8192) ? -8192 : qq;
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge ap_clk);
    while (!bus.ready && guard < 100) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!bus.ready) check("wait ready timeout", 0, 1);
  endtask

  // Issue one operation, scramble inputs during CALC, measure latency to done.
  task automatic run_op(input int a, input int b, output int lat, output logic rdy_low);
    wait_ready();
    bus.start = 1'b1;
    bus.din0  = 24'(a);
    bus.din1  = 10'(b);
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.start = 1'b0;
    bus.din0  = 24'(a) ^ 24'h5a5a5a;
    bus.din1  = 10'(b + 3);
    lat     = -1;
    rdy_low = !bus.ready;
    for (int i = 1; i <= 40; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.ready) rdy_low = 1'b0;
    end
  endtask

  vec_t vecs[17];

  initial begin
    int   lat;
    logic rdy_low;
    int   eq, er, n_done;

    vecs[0]  = '{1000, 7, 142, 6, 1'b0, 1'b0};
    vecs[1]  = '{-1000, 7, -142, -6, 1'b0, 1'b0};
    vecs[2]  = '{1000, -7, -142, 6, 1'b0, 1'b0};
    vecs[3]  = '{-1000, -7, 142, -6, 1'b0, 1'b0};
    vecs[4]  = '{100000, 3, 8191, 1, 1'b1, 1'b0};
    vecs[5]  = '{-8388608, -1, 8191, 0, 1'b1, 1'b0};
    vecs[6]  = '{-8388608, 1, -8192, 0, 1'b1, 1'b0};
    vecs[7]  = '{5, 0, 8191, 0, 1'b1, 1'b1};
    vecs[8]  = '{-5, 0, -8192, 0, 1'b1, 1'b1};
    vecs[9]  = '{0, 5, 0, 0, 1'b0, 1'b0};
    vecs[10] = '{-81920, 10, -8192, 0, 1'b0, 1'b0};
    vecs[11] = '{81910, 10, 8191, 0, 1'b0, 1'b0};
    vecs[12] = '{81920, 10, 8191, 0, 1'b1, 1'b0};
    vecs[13] = '{1023, -512, -1, 511, 1'b0, 1'b0};
    vecs[14] = '{-6, 3, -2, 0, 1'b0, 1'b0};
    vecs[15] = '{8388607, 511, 8191, 31, 1'b1, 1'b0};
    vecs[16] = '{-81929, 10, -8192, -9, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;

    #12;
    check("reset ready", bus.ready, 1);
    check("reset done",  bus.done,  0);
    check("reset quot",  sq(bus.quot), 0);
    check("reset rem",   sr(bus.rem),  0);
    check("reset ovf",   bus.ovf,  0);
    check("reset div0",  bus.div0, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, rdy_low);
      check($sformatf("v%0d latency", i), lat, 25);
      check($sformatf("v%0d ready low", i), rdy_low, 1);
      check($sformatf("v%0d quot", i), sq(bus.quot), vecs[i].q);
      check($sformatf("v%0d rem", i),  sr(bus.rem),  vecs[i].r);
      check($sformatf("v%0d ovf", i),  bus.ovf,  vecs[i].o);
      check($sformatf("v%0d div0", i), bus.div0, vecs[i].d);
    end

    // start held high with changing operands: accepts land 26 cycles apart.
    wait_ready();
    n_done = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge ap_clk);
      check($sformatf("b2b done k=%0d", k), bus.done, (k == 26 || k == 52 || k == 78));
      if (bus.done) begin
        n_done++;
        model(2000 + 10 * (k - 26), 7, eq, er);
        check($sformatf("b2b quot k=%0d", k), sq(bus.quot), eq);
        check($sformatf("b2b rem k=%0d", k),  sr(bus.rem),  er);
      end
      bus.start = 1'b1;
      bus.din0  = 24'(2000 + 10 * k);
      bus.din1  = (k % 26 == 0) ? 10'd7 : 10'(3 + k % 5);
    end
    bus.start = 1'b0;
    check("b2b done count", n_done, 3);

    // Abort at CALC iteration 10 with asynchronous reset.
    wait_ready();
    bus.start = 1'b1;
    bus.din0  = 24'(1000);
    bus.din1  = 10'(7);
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("abort ready", bus.ready, 1);
    check("abort done",  bus.done,  0);
    check("abort quot",  sq(bus.quot), 0);
    check("abort rem",   sr(bus.rem),  0);
    check("abort ovf",   bus.ovf,  0);
    check("abort div0",  bus.div0, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (bus.done) n_done++;
    end
    check("abort no done", n_done, 0);

    run_op(-7, 2, lat, rdy_low);
    check("post abort latency", lat, 25);
    check("post abort quot", sq(bus.quot), -3);
    check("post abort rem",  sr(bus.rem),  -1);
    check("post abort ovf",  bus.ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
